usr_cmd_scheduler: RTL and testbench

- Two-requester command scheduler for the 4-bit universal shift register (USR).
- Sits between two independent command sources and the USR.
- Round-robin arbitrates between the requesters, then sequences the granted command by driving the USR select and load buses for the required number of cycles.
- Returns a done pulse with the USR result and the requester ID.

---
 rtl/usr_ops_pkg.sv | 38 +++
 rtl/rr_arb2.sv | 34 +++
 rtl/usr_cmd_scheduler.sv | 144 ++++++++++++++
 tb/tb_usr_cmd_scheduler.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/usr_ops_pkg.sv
// Shared definitions for the USR command scheduler: opcode encodings,
// scheduler FSM states, default widths and the opcode normalisation helper.
package usr_ops_pkg;

  // Default datapath width and repeat-count width
  localparam int USR_W  = 4;
  localparam int USR_CW = 4;

  // USR select-bus encodings
  localparam logic [2:0] OP_HOLD = 3'd0;
  localparam logic [2:0] OP_SHR  = 3'd1;
  localparam logic [2:0] OP_SHL  = 3'd2;
  localparam logic [2:0] OP_LOAD = 3'd3;
  localparam logic [2:0] OP_ROR  = 3'd4;
  localparam logic [2:0] OP_ROL  = 3'd5;
  localparam logic [2:0] OP_CLR  = 3'd6;
  localparam logic [2:0] OP_RSVD = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } sched_state_e;

  // LOAD/CLR run once regardless of count; a zero count on any other op
  // degenerates to a single HOLD, and the reserved opcode behaves as HOLD.
  function automatic logic [2:0] exec_op(input logic [2:0] op, input logic cnt_zero);
    logic [2:0] eff;
    eff = op;
    if (op == OP_RSVD) begin
      eff = OP_HOLD;
    end else if (cnt_zero && (op != OP_LOAD) && (op != OP_CLR)) begin
      eff = OP_HOLD;
    end
    return eff;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. Grant is combinational from the requests and
// the last-served pointer; the pointer only moves when a grant is accepted.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  // Last-served requester; resets to 1 so requester 0 wins the first tie.
  logic last_reg;

  // Grant the lone requester, or the one not served last when both ask.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_reg ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Remember who was served on each accepted command.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_reg <= 1'b1;
    end else if (accept) begin
      last_reg <= grant[1];
    end
  end

endmodule

// File: rtl/usr_cmd_scheduler.sv
// Two-requester command scheduler for the universal shift register.
// Arbitrates, latches the winning command, drives S/L for the required number
// of cycles and reports completion with the captured USR value.
module usr_cmd_scheduler
  import usr_ops_pkg::*;
#(
  parameter int W  = USR_W,
  parameter int CW = USR_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    req_valid,
  input  logic [2:0]    req_op0,
  input  logic [2:0]    req_op1,
  input  logic [CW-1:0] req_cnt0,
  input  logic [CW-1:0] req_cnt1,
  input  logic [W-1:0]  req_data0,
  input  logic [W-1:0]  req_data1,
  output logic [1:0]    req_ready,
  output logic [2:0]    S,
  output logic [W-1:0]  L,
  input  logic [W-1:0]  q_in,
  output logic          busy,
  output logic          done,
  output logic          done_id,
  output logic [W-1:0]  result
);

  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  sched_state_e  state_reg, state_next;
  logic [2:0]    s_reg, s_next;
  logic [W-1:0]  l_reg, l_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          id_reg, id_next;
  logic          done_reg, done_next;
  logic          done_id_reg, done_id_next;
  logic [W-1:0]  result_reg, result_next;

  logic [1:0]    grant;
  logic          accept;
  logic          sel_id;
  logic [2:0]    sel_op;
  logic [CW-1:0] sel_cnt;
  logic [W-1:0]  sel_data;
  logic          sel_force_one;
  logic          sel_cnt_zero;
  logic [2:0]    sel_exec_op;

  rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (req_valid),
    .accept (accept),
    .grant  (grant)
  );

  // Grant only reaches a valid requester, so any grant in IDLE is a transfer.
  assign accept    = (state_reg == ST_IDLE) && (grant != 2'b00);
  assign req_ready = (state_reg == ST_IDLE) ? grant : 2'b00;
  assign busy      = (state_reg != ST_IDLE);

  assign S       = s_reg;
  assign L       = l_reg;
  assign done    = done_reg;
  assign done_id = done_id_reg;
  assign result  = result_reg;

  // Mux the granted requester's fields and normalise them into op/count.
  assign sel_id        = grant[1];
  assign sel_op        = sel_id ? req_op1   : req_op0;
  assign sel_cnt       = sel_id ? req_cnt1  : req_cnt0;
  assign sel_data      = sel_id ? req_data1 : req_data0;
  assign sel_force_one = (sel_op == OP_LOAD) || (sel_op == OP_CLR);
  assign sel_cnt_zero  = (sel_cnt == '0);
  assign sel_exec_op   = exec_op(sel_op, sel_cnt_zero);

  // Next-state and next-output logic; everything holds unless a state acts.
  always_comb begin
    state_next   = state_reg;
    s_next       = s_reg;
    l_next       = l_reg;
    cnt_next     = cnt_reg;
    id_next      = id_reg;
    done_next    = 1'b0;
    done_id_next = done_id_reg;
    result_next  = result_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_EXEC;
          id_next    = sel_id;
          s_next     = sel_exec_op;
          // L stays at zero whenever the select is HOLD.
          l_next     = (sel_exec_op == OP_HOLD) ? '0 : sel_data;
          cnt_next   = (sel_force_one || sel_cnt_zero) ? CNT_ONE : sel_cnt;
        end
      end
      ST_EXEC: begin
        cnt_next = cnt_reg - CNT_ONE;
        if (cnt_reg == CNT_ONE) begin
          state_next   = ST_DONE;
          s_next       = OP_HOLD;
          l_next       = '0;
          done_next    = 1'b1;
          done_id_next = id_reg;
        end
      end
      ST_DONE: begin
        // The USR has taken its last EXEC edge by now, so q_in is final;
        // it lands in result on the edge that leaves DONE.
        result_next = q_in;
        state_next  = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops any in-flight command.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= ST_IDLE;
      s_reg       <= OP_HOLD;
      l_reg       <= '0;
      cnt_reg     <= '0;
      id_reg      <= 1'b0;
      done_reg    <= 1'b0;
      done_id_reg <= 1'b0;
      result_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      s_reg       <= s_next;
      l_reg       <= l_next;
      cnt_reg     <= cnt_next;
      id_reg      <= id_next;
      done_reg    <= done_next;
      done_id_reg <= done_id_next;
      result_reg  <= result_next;
    end
  end

endmodule

// File: tb/tb_usr_cmd_scheduler.sv
// Self-checking bench for usr_cmd_scheduler with a behavioural USR attached.
module tb_usr_cmd_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] req_valid = 2'b00;
  logic [2:0] req_op0 = 3'd0, req_op1 = 3'd0;
  logic [3:0] req_cnt0 = 4'd0, req_cnt1 = 4'd0;
  logic [3:0] req_data0 = 4'd0, req_data1 = 4'd0;
  logic [1:0] req_ready;
  logic [2:0] S;
  logic [3:0] L;
  logic [3:0] q_in;
  logic       busy, done, done_id;
  logic [3:0] result;

  int checks = 0;
  int passes = 0;

  usr_cmd_scheduler dut (
    .clk(clk), .reset(reset), .req_valid(req_valid),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_cnt0(req_cnt0), .req_cnt1(req_cnt1),
    .req_data0(req_data0), .req_data1(req_data1),
    .req_ready(req_ready), .S(S), .L(L), .q_in(q_in),
    .busy(busy), .done(done), .done_id(done_id), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else passes++;
  endtask

  // Behavioural 4-bit USR, zero serial fill, driven by the scheduler.
  logic [3:0] usr_q;
  always @(posedge clk or negedge reset) begin
    if (!reset) usr_q <= 4'd0;
    else begin
      case (S)
        3'd1: usr_q <= {1'b0, usr_q[3:1]};
        3'd2: usr_q <= {usr_q[2:0], 1'b0};
        3'd3: usr_q <= L;
        3'd4: usr_q <= {usr_q[0], usr_q[3:1]};
        3'd5: usr_q <= {usr_q[2:0], usr_q[3]};
        3'd6: usr_q <= 4'd0;
        default: usr_q <= usr_q;
      endcase
    end
  end
  assign q_in = usr_q;

  // Effect of n repetitions of an operation on a register value.
  function automatic logic [3:0] apply_op(input logic [3:0] q, input int op, input int n, input logic [3:0] d);
    logic [3:0] v;
    v = q;
    for (int i = 0; i < n; i++) begin
      case (op)
        1: v = v >> 1;
        2: v = v << 1;
        3: v = d;
        4: v = {v[0], v[3:1]};
        5: v = {v[2:0], v[3]};
        6: v = 4'd0;
        default: v = v;
      endcase
    end
    return v;
  endfunction

  function automatic logic [1:0] rr_pick(input logic [1:0] v, input logic last);
    if (v == 2'b11) return last ? 2'b01 : 2'b10;
    return v;
  endfunction

  // Model: one accepted command occupies EXEC cycles a..a+n-1, DONE at a+n,
  // result visible from a+n+1; acceptance only from an idle cycle.
  int         cyc = 0;
  logic       m_has = 1'b0, m_last = 1'b1, m_id = 1'b0, m_did = 1'b0;
  int         m_a = 0, m_n = 0;
  logic [2:0] m_op = 3'd0;
  logic [3:0] m_l = 4'd0, m_q = 4'd0, m_res = 4'd0;
  int         p_op, p_cnt;
  logic [3:0] p_data;
  logic       p_id;

  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      m_has = 1'b0; m_last = 1'b1; m_did = 1'b0; m_res = 4'd0; m_q = 4'd0;
    end else begin
      if (m_has && cyc == m_a + m_n) m_did = m_id;
      if (m_has && cyc == m_a + m_n + 1) m_res = m_q;
      if ((!m_has || (cyc - 1 >= m_a + m_n + 1)) && req_valid != 2'b00) begin
        p_id   = rr_pick(req_valid, m_last) == 2'b10;
        p_op   = p_id ? int'(req_op1) : int'(req_op0);
        p_cnt  = p_id ? int'(req_cnt1) : int'(req_cnt0);
        p_data = p_id ? req_data1 : req_data0;
        if (p_op == 3 || p_op == 6) begin m_n = 1; m_op = 3'(p_op); end
        else if (p_cnt == 0) begin m_n = 1; m_op = 3'd0; end
        else begin m_n = p_cnt; m_op = (p_op == 7) ? 3'd0 : 3'(p_op); end
        m_l    = (m_op == 3'd0) ? 4'd0 : p_data;
        m_q    = apply_op(m_q, int'(m_op), m_n, p_data);
        m_has  = 1'b1; m_a = cyc; m_id = p_id; m_last = p_id;
      end
    end
  end

  // Compare every cycle away from the active edge.
  logic done_q[$];
  always @(negedge clk) begin
    if (cyc > 0) begin
      logic ex, dn;
      if (!reset) begin
        chk("rst_S", 32'(S), 0); chk("rst_L", 32'(L), 0);
        chk("rst_ready", 32'(req_ready), 0); chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0); chk("rst_done_id", 32'(done_id), 0);
        chk("rst_result", 32'(result), 0);
      end else begin
        ex = m_has && cyc >= m_a && cyc < m_a + m_n;
        dn = m_has && cyc == m_a + m_n;
        chk("S", 32'(S), ex ? 32'(m_op) : 0);
        chk("L", 32'(L), ex ? 32'(m_l) : 0);
        chk("busy", 32'(busy), 32'(ex | dn));
        chk("done", 32'(done), 32'(dn));
        chk("done_id", 32'(done_id), 32'(dn ? m_id : m_did));
        chk("result", 32'(result), 32'(m_res));
        chk("req_ready", 32'(req_ready), (ex | dn) ? 0 : 32'(rr_pick(req_valid, m_last)));
        if (done) done_q.push_back(done_id);
      end
    end
  end

  int last_busy, last_s;

  task automatic wait_ready(input int id);
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready[id]) begin ok = 1; break; end
    end
    if (!ok) chk("timeout_ready", 0, 1);
  endtask

  task automatic wait_idle(input int op);
    bit ok = 0;
    last_busy = 0; last_s = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
      last_busy++;
      if (int'(S) == op) last_s++;
    end
    if (!ok) chk("timeout_idle", 0, 1);
  endtask

  task automatic issue(input int id, input int op, input int cnt, input logic [3:0] data);
    @(posedge clk); #2;
    if (id == 0) begin req_op0 = 3'(op); req_cnt0 = 4'(cnt); req_data0 = data; end
    else begin req_op1 = 3'(op); req_cnt1 = 4'(cnt); req_data1 = data; end
    req_valid[id] = 1'b1;
    wait_ready(id);
    @(posedge clk); #2;
    req_valid[id] = 1'b0;
    wait_idle(op);
  endtask

  initial begin
    logic [1:0] order[4];
    int n_acc, dq0, dn_rst;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;

    issue(0, 3, 1, 4'b1010);
    chk("lit_load_result", 32'(result), 32'h a);
    chk("lit_load_busy", 32'(last_busy), 2);
    chk("lit_load_scycles", 32'(last_s), 1);

    issue(0, 3, 1, 4'b0001);
    issue(1, 2, 3, 4'b0000);
    chk("lit_shl_result", 32'(result), 32'h 8);
    chk("lit_shl_scycles", 32'(last_s), 3);
    chk("lit_shl_busy", 32'(last_busy), 4);

    issue(0, 4, 0, 4'b0101);
    chk("lit_cnt0_result", 32'(result), 32'h 8);
    chk("lit_cnt0_busy", 32'(last_busy), 2);

    issue(1, 3, 1, 4'b0001);
    issue(0, 4, 15, 4'b0000);
    chk("lit_ror15_result", 32'(result), 32'h 2);
    chk("lit_ror15_scycles", 32'(last_s), 15);

    issue(1, 7, 3, 4'b1111);
    chk("lit_op7_result", 32'(result), 32'h 2);

    // Handshake: requester 1 waits through requester 0's command; its data
    // changes while blocked and only the value at acceptance is used.
    @(posedge clk); #2;
    req_op0 = 3'd5; req_cnt0 = 4'd2; req_data0 = 4'd0;
    req_op1 = 3'd3; req_cnt1 = 4'd1; req_data1 = 4'b0110;
    req_valid = 2'b11;
    @(negedge clk);
    chk("lit_hs_ready", 32'(req_ready), 32'h 1);
    @(posedge clk); #2 req_valid[0] = 1'b0;
    @(posedge clk); #2 req_data1 = 4'b1100;
    @(negedge clk);
    chk("lit_hs_blocked", 32'(req_ready[1]), 0);
    wait_ready(1);
    @(posedge clk); #2 req_valid[1] = 1'b0;
    wait_idle(3);
    chk("lit_hs_result", 32'(result), 32'h c);

    // Reset in the middle of a ROL cnt=5.
    @(posedge clk); #2;
    req_op0 = 3'd5; req_cnt0 = 4'd5; req_data0 = 4'd0; req_valid = 2'b01;
    wait_ready(0);
    @(posedge clk); #2 req_valid = 2'b00;
    @(posedge clk); @(posedge clk); #2 reset = 1'b0;
    dn_rst = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) dn_rst++;
    end
    chk("lit_rst_S", 32'(S), 0);
    chk("lit_rst_busy", 32'(busy), 0);
    @(posedge clk); #2;
    reset = 1'b1;
    req_op0 = 3'd3; req_cnt0 = 4'd1; req_data0 = 4'd3;
    req_op1 = 3'd3; req_cnt1 = 4'd1; req_data1 = 4'd4;
    req_valid = 2'b11;
    @(negedge clk);
    if (done) dn_rst++;
    chk("lit_rst_no_done", 32'(dn_rst), 0);
    chk("lit_rst_ready", 32'(req_ready), 32'h 1);

    // Round-robin with both requesters continuously valid.
    dq0 = done_q.size();
    n_acc = 0;
    for (int i = 0; i < 200 && n_acc < 4; i++) begin
      if (i > 0) @(negedge clk);
      if (req_ready != 2'b00) begin
        order[n_acc] = req_ready;
        n_acc++;
        @(posedge clk); #2;
        if (req_ready[0]) req_data0 = req_data0 + 4'd1;
        if (n_acc == 4) req_valid = 2'b00;
        else if (order[n_acc-1] == 2'b01) req_data0 = req_data0 + 4'd2;
        else req_data1 = req_data1 + 4'd2;
      end
    end
    chk("lit_rr_accepts", 32'(n_acc), 4);
    wait_idle(3);
    chk("lit_rr_g0", 32'(order[0]), 32'h 1);
    chk("lit_rr_g1", 32'(order[1]), 32'h 2);
    chk("lit_rr_g2", 32'(order[2]), 32'h 1);
    chk("lit_rr_g3", 32'(order[3]), 32'h 2);
    chk("lit_rr_ndone", 32'(done_q.size() - dq0), 4);
    if (done_q.size() - dq0 == 4) begin
      chk("lit_rr_id0", 32'(done_q[dq0]), 0);
      chk("lit_rr_id1", 32'(done_q[dq0+1]), 1);
      chk("lit_rr_id2", 32'(done_q[dq0+2]), 0);
      chk("lit_rr_id3", 32'(done_q[dq0+3]), 1);
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
